ps2_key_decoder: RTL

//  Front end for the maze game controller: receives PS/2 keyboard frames and decodes

---
 rtl/ps2_key_decoder_pkg.sv | 72 +++++++
 rtl/ps2_key_decoder_if.sv | 30 +++
 rtl/ps2_key_decoder_ps2_rx.sv | 125 ++++++++++++
 rtl/ps2_key_decoder.sv | 103 ++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_pkg
//   Shared definitions for the PS/2 keyboard front end and the maze game
//   controller: the 3-bit move code, the PS/2 scan-code constants the decoder
//   cares about, and helpers that map a scan code to a move and a move to its
//   bit in the held mask.
// ---------------------------------------------------------------------------
package ps2_key_decoder_pkg;

  // Move code shared with the maze controller.
  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_LEFT  = 3'd1,
    MV_RIGHT = 3'd2,
    MV_UP    = 3'd3,
    MV_DOWN  = 3'd4
  } move_e;

  // Prefix bytes.
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Plain (WASD) direction codes.
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;

  // Extended (arrow) direction codes, valid only after SC_EXT.
  localparam logic [7:0] SC_E_LEFT  = 8'h6B;
  localparam logic [7:0] SC_E_RIGHT = 8'h74;
  localparam logic [7:0] SC_E_UP    = 8'h75;
  localparam logic [7:0] SC_E_DOWN  = 8'h72;

  // Scan code to move; anything unmapped gives MV_NONE.
  function automatic move_e map_code(input logic ext, input logic [7:0] code);
    move_e mv;
    mv = MV_NONE;
    if (ext) begin
      case (code)
        SC_E_LEFT:  mv = MV_LEFT;
        SC_E_RIGHT: mv = MV_RIGHT;
        SC_E_UP:    mv = MV_UP;
        SC_E_DOWN:  mv = MV_DOWN;
        default:    mv = MV_NONE;
      endcase
    end else begin
      case (code)
        SC_A:    mv = MV_LEFT;
        SC_D:    mv = MV_RIGHT;
        SC_W:    mv = MV_UP;
        SC_S:    mv = MV_DOWN;
        default: mv = MV_NONE;
      endcase
    end
    return mv;
  endfunction

  // Move to its one-hot position in held = {down,up,right,left}.
  function automatic logic [3:0] held_mask(input move_e mv);
    logic [3:0] m;
    case (mv)
      MV_LEFT:  m = 4'b0001;
      MV_RIGHT: m = 4'b0010;
      MV_UP:    m = 4'b0100;
      MV_DOWN:  m = 4'b1000;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
//   Key mailbox link between the PS/2 decoder (master) and the maze game
//   controller (slave).
//     key        decoder -> ctrl  move code of the newest press
//     key_valid  decoder -> ctrl  mailbox full
//     key_ack    ctrl -> decoder  key consumed (honoured only while key_valid)
//     held       decoder -> ctrl  {down,up,right,left} physically-down mask
//     frame_err  decoder -> ctrl  one-cycle PS/2 framing error pulse
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
  import ps2_key_decoder_pkg::*;

  move_e      key;
  logic       key_valid;
  logic       key_ack;
  logic [3:0] held;
  logic       frame_err;

  modport master (
    output key, key_valid, held, frame_err,
    input  key_ack
  );

  modport slave (
    input  key, key_valid, held, frame_err,
    output key_ack
  );

endinterface

// File: rtl/ps2_key_decoder_ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_ps2_rx
//   PS/2 byte receiver: two-flop synchronisers on the raw pins, falling-edge
//   detect on the PS/2 clock, 11-bit frame FSM (start, 8 data LSB first, odd
//   parity, stop) and an inactivity timeout that aborts partial frames.
//   Ports:
//     clk, reset      system clock, synchronous active-high reset
//     ps2_clk_i       raw PS/2 clock pin (asynchronous)
//     ps2_dat_i       raw PS/2 data pin (asynchronous)
//     rx_byte_o       last received byte, valid with rx_strobe_o
//     rx_strobe_o     one-cycle pulse for a good frame
//     frame_err_o     one-cycle pulse on parity, stop-bit or timeout error
// ---------------------------------------------------------------------------
module ps2_key_decoder_ps2_rx #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       frame_err_o
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  logic [1:0]       state_q,  state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,  shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             strobe_q, strobe_d;
  logic             err_q,    err_d;

  logic fe;
  assign fe = clk_prev_q & ~clk_sync_q;

  // NOTE: every always_comb target is defaulted first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    cnt_d     = (state_q == ST_IDLE || fe) ? '0 : cnt_q + CNT_W'(1);

    if (state_q != ST_IDLE && !fe && cnt_q == CNT_LAST) begin
      // Device stopped clocking mid-frame: drop the partial byte.
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (fe) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = dat_sync_q;
          state_d  = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (dat_sync_q && (^{shift_q, parity_q})) strobe_d = 1'b1;
          else                                      err_d    = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  // The shift register is idle for many cycles after the stop bit, so the
  // byte is stable while the strobe is high.
  assign rx_byte_o   = shift_q;
  assign rx_strobe_o = strobe_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   PS/2 keyboard front end for the maze game controller. Decodes arrow keys
//   and WASD into the shared move code, holds the newest press in a one-deep
//   mailbox until acknowledged, tracks which directions are held down and
//   forwards framing errors.
//   Ports:
//     clk, reset   system clock, synchronous active-high reset
//     ps2_clk      raw PS/2 clock pin (asynchronous)
//     ps2_dat      raw PS/2 data pin (asynchronous)
//     kbd          mailbox link (key, key_valid, key_ack, held, frame_err)
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  ps2_key_decoder_if.master     kbd
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_err;

  ps2_key_decoder_ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .rx_byte_o   (rx_byte),
    .rx_strobe_o (rx_strobe),
    .frame_err_o (rx_err)
  );

  logic       ext_q,   ext_d;
  logic       brk_q,   brk_d;
  logic [3:0] held_q,  held_d;
  move_e      key_q,   key_d;
  logic       valid_q, valid_d;
  move_e      code_mv;

  assign code_mv = map_code(ext_q, rx_byte);

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    held_d  = held_q;
    key_d   = key_q;
    valid_d = valid_q;

    if (valid_q && kbd.key_ack) begin
      valid_d = 1'b0;
      key_d   = MV_NONE;
    end

    // Evaluated after the ack so a simultaneous make refills the mailbox.
    if (rx_strobe) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (code_mv != MV_NONE) begin
          if (brk_q) begin
            held_d = held_q & ~held_mask(code_mv);
          end else begin
            held_d  = held_q | held_mask(code_mv);
            key_d   = code_mv;
            valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      held_q  <= 4'b0000;
      key_q   <= MV_NONE;
      valid_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      held_q  <= held_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  assign kbd.key       = key_q;
  assign kbd.key_valid = valid_q;
  assign kbd.held      = held_q;
  assign kbd.frame_err = rx_err;

endmodule
